iter_divider: RTL and testbench

- Multi-cycle restoring divider for the MIPS DIV/DIVU path; the subtractive counterpart to the single-cycle adder.
- Each iteration performs one (p_nbits+1)-bit trial subtraction of the divisor from the partial remainder, producing one quotient bit per cycle.
- Sits beside the ALU in EX and writes HI (remainder) and LO (quotient) through a val/rdy response.

---
 rtl/iter_divider.sv | 102 ++++++++++
 tb/tb_iter_divider.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign fixup applied when the result is registered into the response.
module iter_divider #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic               req_signed,
    input  logic [p_nbits-1:0] req_dividend,
    input  logic [p_nbits-1:0] req_divisor,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_quotient,
    output logic [p_nbits-1:0] resp_remainder,
    output logic               busy
);
    localparam int CW = $clog2(p_nbits);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [p_nbits-1:0] r_rem, r_quo, r_dvs, r_q_out, r_r_out;
    logic               r_qneg, r_rneg;

    logic               w_accept, w_last;
    logic               w_dd_neg, w_dv_neg;
    logic [p_nbits-1:0] w_dd_mag, w_dv_mag;
    logic [p_nbits:0]   w_rem_sh;
    logic [p_nbits+1:0] w_diff;
    logic               w_borrow;
    logic [p_nbits-1:0] w_rem_nx, w_quo_nx;

    assign w_accept = (r_state == IDLE) && req_val && !flush;
    assign w_last   = (r_state == CALC) && (r_cnt == '0) && !flush;

    // Magnitudes wrap in unsigned arithmetic, so |MIN| comes out exact.
    assign w_dd_neg = req_signed & req_dividend[p_nbits-1];
    assign w_dv_neg = req_signed & req_divisor[p_nbits-1];
    assign w_dd_mag = w_dd_neg ? -req_dividend : req_dividend;
    assign w_dv_mag = w_dv_neg ? -req_divisor  : req_divisor;

    assign w_rem_sh = {r_rem, r_quo[p_nbits-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_dvs};
    // A successful trial is always below 2^p_nbits, so either top bit set means borrow.
    assign w_borrow = |w_diff[p_nbits+1:p_nbits];
    assign w_rem_nx = w_borrow ? w_rem_sh[p_nbits-1:0] : w_diff[p_nbits-1:0];
    assign w_quo_nx = {r_quo[p_nbits-2:0], ~w_borrow};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (flush) w_next = IDLE;
                     else if (r_cnt == '0) w_next = DONE;
            DONE:    if (flush || resp_rdy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_q_out <= '0;
            r_r_out <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_quo  <= w_dd_mag;
                r_dvs  <= w_dv_mag;
                r_rem  <= '0;
                r_cnt  <= CW'(p_nbits - 1);
                r_qneg <= w_dd_neg ^ w_dv_neg;
                r_rneg <= w_dd_neg;
            end else if (r_state == CALC) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_last) begin
                r_q_out <= r_qneg ? -w_quo_nx : w_quo_nx;
                r_r_out <= r_rneg ? -w_rem_nx : w_rem_nx;
            end
        end
    end

    assign req_rdy        = (r_state == IDLE) && resetn;
    assign resp_val       = (r_state == DONE);
    assign busy           = (r_state != IDLE);
    assign resp_quotient  = r_q_out;
    assign resp_remainder = r_r_out;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: arithmetic corners, latency, backpressure,
// flush and asynchronous reset.
module tb_iter_divider;
    logic        clk = 1'b0;
    logic        resetn, flush, req_val, req_signed, resp_rdy;
    logic [31:0] req_dividend, req_divisor;
    logic        req_rdy, resp_val, busy;
    logic [31:0] resp_quotient, resp_remainder;

    int total = 0;
    int bad   = 0;

    iter_divider #(.p_nbits(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req_val(req_val), .req_rdy(req_rdy), .req_signed(req_signed),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .resp_val(resp_val), .resp_rdy(resp_rdy),
        .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Request is driven just after edge E0, sampled at E1; response expected after E0+33.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        req_signed   = s;
        req_dividend = a;
        req_divisor  = b;
        req_val      = 1'b1;
        step();
        req_val = 1'b0;
        repeat (31) step();
        chk("lat_not_yet", {31'd0, resp_val}, 32'd0);
        step();
        chk("lat_resp_val", {31'd0, resp_val}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        start_op(s, a, b);
        chk({tag, "_quo"}, resp_quotient, eq);
        chk({tag, "_rem"}, resp_remainder, er);
        step();
        chk({tag, "_val_drop"}, {31'd0, resp_val}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, req_rdy}, 32'd1);
    endtask

    initial begin
        logic seen;
        resetn = 1'b0; flush = 1'b0; req_val = 1'b0; req_signed = 1'b0;
        req_dividend = '0; req_divisor = '0; resp_rdy = 1'b1;
        #12;
        chk("rst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_quo", resp_quotient, 32'd0);
        chk("rst_rem", resp_remainder, 32'd0);
        resetn = 1'b1;
        step();
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'h0000_0001, 32'hFFFF_FFFB);

        // Backpressure: result held, requests ignored while DONE.
        resp_rdy = 1'b0;
        start_op(1'b0, 32'd50, 32'd6);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                req_val = 1'b1; req_dividend = 32'd9; req_divisor = 32'd3;
            end else begin
                req_val = 1'b0;
            end
            chk("bp_val", {31'd0, resp_val}, 32'd1);
            chk("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
            chk("bp_quo", resp_quotient, 32'd8);
            chk("bp_rem", resp_remainder, 32'd2);
            step();
        end
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        step();
        chk("bp_handshake_drop", {31'd0, resp_val}, 32'd0);
        step();
        chk("bp_no_second", {31'd0, busy}, 32'd0);

        // flush together with req_val in IDLE: not accepted.
        req_val = 1'b1; flush = 1'b1; req_dividend = 32'd20; req_divisor = 32'd4;
        step();
        req_val = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", {31'd0, busy}, 32'd0);

        // flush mid-CALC: back to IDLE, no response ever.
        req_val = 1'b1; req_signed = 1'b0; req_dividend = 32'd77; req_divisor = 32'd5;
        step();
        req_val = 1'b0;
        repeat (4) step();
        chk("flush_calc_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_calc_busy", {31'd0, busy}, 32'd0);
        chk("flush_calc_req_rdy", {31'd0, req_rdy}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resp_val) seen = 1'b1;
            step();
        end
        chk("flush_no_resp", {31'd0, seen}, 32'd0);
        chk("flush_quo_held", resp_quotient, 32'd8);

        // Asynchronous reset mid-CALC.
        req_val = 1'b1; req_dividend = 32'd500; req_divisor = 32'd3;
        step();
        req_val = 1'b0;
        repeat (6) step();
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_req_rdy", {31'd0, req_rdy}, 32'd0);
        chk("arst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("arst_quo", resp_quotient, 32'd0);
        chk("arst_rem", resp_remainder, 32'd0);
        #2 resetn = 1'b1;
        step();
        chk("arst_release_rdy", {31'd0, req_rdy}, 32'd1);
        run_op("divu_1000_10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without summary");
        $fatal(1, "timeout");
    end
endmodule
